// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 register-initialisation ROM and issues each entry as an SCCB
// register write, honouring the delay (0xFFF0) and end (0xFFFF) markers.
module ov7670_config_sequencer #(
    parameter int DELAY_CYCLES = 250000,
    parameter int MAX_RETRY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_dout,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_reg,
    output logic [7:0]  cmd_data,
    input  logic        sccb_done,
    input  logic        sccb_err,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CW = $clog2(DELAY_CYCLES + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CW-1:0] DELAY_LOAD  = CW'(DELAY_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
    localparam logic [15:0]   END_MARK    = 16'hFFFF;
    localparam logic [15:0]   DELAY_MARK  = 16'hFFF0;
    localparam logic [7:0]    LAST_ADDR   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_SEND,
        ST_WAIT,
        ST_DELAY,
        ST_NEXT,
        ST_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    addr_d;
    logic          valid_d;
    logic [7:0]    reg_d;
    logic [7:0]    data_d;
    logic          busy_d;
    logic          done_d;
    logic          err_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [CW-1:0] delay_q, delay_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rom_addr  <= '0;
            cmd_valid <= 1'b0;
            cmd_reg   <= '0;
            cmd_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            retry_q   <= '0;
            delay_q   <= '0;
        end else begin
            state_q   <= state_d;
            rom_addr  <= addr_d;
            cmd_valid <= valid_d;
            cmd_reg   <= reg_d;
            cmd_data  <= data_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            retry_q   <= retry_d;
            delay_q   <= delay_d;
        end
    end

    // NOTE: every signal gets its hold value first so no path through the case
    // leaves one unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = rom_addr;
        valid_d = cmd_valid;
        reg_d   = cmd_reg;
        data_d  = cmd_data;
        busy_d  = busy;
        done_d  = done;
        err_d   = err;
        retry_d = retry_q;
        delay_d = delay_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end

            // The ROM read is registered: give it one cycle with the new address.
            ST_FETCH: state_d = ST_DECODE;

            ST_DECODE: begin
                if (rom_dout == END_MARK) begin
                    state_d = ST_FINISH;
                end else if (rom_dout == DELAY_MARK) begin
                    delay_d = DELAY_LOAD;
                    state_d = ST_DELAY;
                end else begin
                    reg_d   = rom_dout[15:8];
                    data_d  = rom_dout[7:0];
                    retry_d = '0;
                    valid_d = 1'b1;
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                if (cmd_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (sccb_done) begin
                    if (!sccb_err) begin
                        state_d = ST_NEXT;
                    end else if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + RW'(1);
                        valid_d = 1'b1;
                        state_d = ST_SEND;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_NEXT;
                    end
                end
            end

            // Counter runs DELAY_CYCLES-1 down to 0 inclusive: DELAY_CYCLES cycles here.
            ST_DELAY: begin
                if (delay_q == '0) begin
                    state_d = ST_NEXT;
                end else begin
                    delay_d = delay_q - CW'(1);
                end
            end

            ST_NEXT: begin
                if (rom_addr == LAST_ADDR) begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    addr_d  = rom_addr + 8'd1;
                    state_d = ST_FETCH;
                end
            end

            ST_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Directed bench for ov7670_config_sequencer: ROM model, SCCB responder with
// scripted NACKs, and one task per scenario with inline comparisons.
module tb_ov7670_config_sequencer;

    localparam int DLY = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dout;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_reg;
    logic [7:0]  cmd_data;
    logic        sccb_done;
    logic        sccb_err;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [15:0] rom [256];
    int          cyc = 0;
    int          fail_count = 0;

    // Written only by the responder/monitor process.
    logic [15:0] xfer [$];
    int          addr_seen [256];
    int          done_seen;
    int          err_used;
    int          resp_at;
    bit          resp_pending;

    ov7670_config_sequencer #(
        .DELAY_CYCLES(DLY),
        .MAX_RETRY   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_reg  (cmd_reg),
        .cmd_data (cmd_data),
        .sccb_done(sccb_done),
        .sccb_err (sccb_err),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) rom_dout <= rom[rom_addr];

    // SCCB slave model: sccb_done is sampled 5 edges after the transfer edge;
    // the first fail_count completions of a run report an error.
    initial begin
        sccb_done    = 1'b0;
        sccb_err     = 1'b0;
        resp_pending = 1'b0;
        err_used     = 0;
        done_seen    = -1;
        foreach (addr_seen[i]) addr_seen[i] = -1;
        forever begin
            @(negedge clk);
            sccb_done = 1'b0;
            sccb_err  = 1'b0;
            if (rst) begin
                resp_pending = 1'b0;
            end else begin
                if (busy && addr_seen[rom_addr] < 0) addr_seen[rom_addr] = cyc;
                if (done && done_seen < 0) done_seen = cyc;
                if (resp_pending && cyc == resp_at) begin
                    sccb_done    = 1'b1;
                    sccb_err     = (err_used < fail_count);
                    if (sccb_err) err_used++;
                    resp_pending = 1'b0;
                end
                if (cmd_valid && cmd_ready) begin
                    xfer.push_back({cmd_reg, cmd_data});
                    resp_pending = 1'b1;
                    resp_at      = cyc + 5;
                end
                if (start && !busy) begin
                    xfer.delete();
                    foreach (addr_seen[i]) addr_seen[i] = -1;
                    done_seen = -1;
                    err_used  = 0;
                end
            end
        end
    end

    task automatic load_rom_a();
        foreach (rom[i]) rom[i] = 16'h0000;
        rom[0] = 16'h1280;
        rom[1] = 16'hFFF0;
        rom[2] = 16'h1204;
        rom[3] = 16'hFFFF;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_timeout: done=%b after %0d cycles, expected 1", name, done, n);
        end
    endtask

    task automatic check_two_writes(input string name, input logic exp_err);
        checks++;
        if (xfer.size() != 2 || xfer[0] !== 16'h1280 || xfer[1] !== 16'h1204) begin
            errors++;
            $display("FAIL %s_writes: got %0d writes (%h %h), expected 2 writes (1280 1204)",
                     name, xfer.size(), (xfer.size() > 0) ? xfer[0] : 16'h0,
                     (xfer.size() > 1) ? xfer[1] : 16'h0);
        end
        checks++;
        if ({busy, done, err} !== {1'b0, 1'b1, exp_err}) begin
            errors++;
            $display("FAIL %s_status: busy/done/err=%b%b%b, expected 01%b", name, busy, done, err, exp_err);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b0;
        cmd_ready = 1'b0;
        load_rom_a();
        repeat (3) @(negedge clk);
        checks++;
        if ({rom_addr, cmd_reg, cmd_data} !== 24'h0) begin
            errors++;
            $display("FAIL reset_regs: addr/reg/data=%h, expected 000000", {rom_addr, cmd_reg, cmd_data});
        end
        checks++;
        if ({cmd_valid, busy, done, err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: valid/busy/done/err=%b, expected 0000", {cmd_valid, busy, done, err});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        load_rom_a();
        fail_count = 0;
        cmd_ready  = 1'b1;
        pulse_start();
        @(negedge clk);
        checks++;
        if ({busy, cmd_valid, rom_addr} !== {1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL basic_fetch: busy=%b valid=%b addr=%h, expected busy=1 valid=0 addr=00", busy, cmd_valid, rom_addr);
        end
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_decode_valid: got %b, expected 0", cmd_valid);
        end
        @(negedge clk);
        checks++;
        if ({cmd_valid, cmd_reg, cmd_data} !== {1'b1, 16'h1280}) begin
            errors++;
            $display("FAIL basic_first_send: valid=%b reg/data=%h, expected valid=1 1280", cmd_valid, {cmd_reg, cmd_data});
        end
        wait_done(300, "basic");
        check_two_writes("basic", 1'b0);
        // FETCH(1), DECODE, 20 DELAY cycles, NEXT, then FETCH(2): 23 cycles apart.
        checks++;
        if (addr_seen[2] - addr_seen[1] != 23) begin
            errors++;
            $display("FAIL basic_delay_span: got %0d cycles, expected 23", addr_seen[2] - addr_seen[1]);
        end
        checks++;
        if (done_seen - addr_seen[3] != 3) begin
            errors++;
            $display("FAIL basic_end_latency: got %0d cycles, expected 3", done_seen - addr_seen[3]);
        end
    endtask

    task automatic test_ready_stall();
        int   n = 0;
        bit   stable = 1'b1;
        logic [15:0] held;
        load_rom_a();
        fail_count = 0;
        cmd_ready  = 1'b0;
        pulse_start();
        while (!cmd_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        held = {cmd_reg, cmd_data};
        repeat (7) begin
            @(negedge clk);
            if (!cmd_valid || {cmd_reg, cmd_data} !== held) stable = 1'b0;
        end
        checks++;
        if (!stable || held !== 16'h1280 || xfer.size() != 0) begin
            errors++;
            $display("FAIL stall_hold: stable=%b held=%h writes=%0d, expected stable=1 held=1280 writes=0",
                     stable, held, xfer.size());
        end
        @(posedge clk); #1 cmd_ready = 1'b1;
        wait_done(300, "stall");
        check_two_writes("stall", 1'b0);
    endtask

    task automatic test_retry(input int nacks, input logic exp_err, input string name);
        int bad = 0;
        load_rom_a();
        fail_count = nacks;
        cmd_ready  = 1'b1;
        pulse_start();
        wait_done(400, name);
        for (int i = 0; i < 3; i++) if (i >= xfer.size() || xfer[i] !== 16'h1280) bad++;
        if (xfer.size() < 4 || xfer[3] !== 16'h1204) bad++;
        checks++;
        if (xfer.size() != 4 || bad != 0) begin
            errors++;
            $display("FAIL %s_writes: got %0d writes with %0d wrong, expected 3x1280 then 1204", name, xfer.size(), bad);
        end
        checks++;
        if ({busy, done, err} !== {1'b0, 1'b1, exp_err}) begin
            errors++;
            $display("FAIL %s_status: busy/done/err=%b%b%b, expected 01%b", name, busy, done, err, exp_err);
        end
        fail_count = 0;
    endtask

    task automatic test_back_to_back();
        load_rom_a();
        cmd_ready = 1'b1;
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_start();
        repeat (10) @(negedge clk);
        pulse_start();
        wait_done(300, "b2b");
        check_two_writes("b2b", 1'b0);
        pulse_start();
        @(negedge clk);
        checks++;
        if ({done, busy, rom_addr} !== {1'b0, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL restart_clear: done=%b busy=%b addr=%h, expected done=0 busy=1 addr=00", done, busy, rom_addr);
        end
        wait_done(300, "restart");
        check_two_writes("restart", 1'b0);
    endtask

    task automatic test_reset_in_delay();
        int n = 0;
        load_rom_a();
        cmd_ready = 1'b1;
        pulse_start();
        while (rom_addr != 8'h01 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, cmd_valid, rom_addr, done, err} !== 12'h0) begin
            errors++;
            $display("FAIL rst_delay_async: busy=%b valid=%b addr=%h done=%b err=%b, expected all 0",
                     busy, cmd_valid, rom_addr, done, err);
        end
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        wait_done(300, "replay");
        check_two_writes("replay", 1'b0);
    endtask

    task automatic test_no_end_marker();
        int bad = 0;
        foreach (rom[i]) begin
            logic [7:0] r;
            r      = 8'(i);
            rom[i] = {r, r ^ 8'h5A};
        end
        cmd_ready = 1'b1;
        pulse_start();
        wait_done(6000, "noend");
        for (int i = 0; i < 256; i++) begin
            logic [7:0] r;
            r = 8'(i);
            if (i >= xfer.size() || xfer[i] !== {r, r ^ 8'h5A}) bad++;
        end
        checks++;
        if (xfer.size() != 256 || bad != 0) begin
            errors++;
            $display("FAIL noend_writes: got %0d writes with %0d wrong, expected 256 in order", xfer.size(), bad);
        end
        checks++;
        if ({busy, done, err, rom_addr} !== {3'b011, 8'hFF}) begin
            errors++;
            $display("FAIL noend_status: busy/done/err=%b%b%b addr=%h, expected 011 addr=ff",
                     busy, done, err, rom_addr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ready_stall();
        test_retry(2, 1'b0, "retry_ok");
        test_retry(3, 1'b1, "retry_fail");
        test_back_to_back();
        test_reset_in_delay();
        test_no_end_marker();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ov7670_config_sequencer.md
# ov7670_config_sequencer

Sequences the OV7670 register-initialisation ROM and drives each entry to the SCCB master as a register write. It sits between the config ROM (8-bit address, 16-bit registered data) and the SCCB master. It interprets the ROM's 0xFFF0 delay marker and 0xFFFF end marker, retries failed writes, and reports completion to the top-level camera bring-up logic.

## Interface
- DELAY_CYCLES, 250000: clk cycles spent on a 0xFFF0 entry (10 ms at 25 MHz).
- MAX_RETRY, 2: extra attempts per entry after an SCCB error.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse; begins the sequence from ROM address 0.
- rom_addr  out  8  address to config ROM.
- rom_dout  in  16  ROM data: [15:8] register, [7:0] value. Valid one cycle after rom_addr changes (registered read).
- cmd_valid  out  1  write command valid to SCCB master.
- cmd_ready  in  1  SCCB master can accept a command.
- cmd_reg  out  8  register address for the SCCB write.
- cmd_data  out  8  data byte for the SCCB write.
- sccb_done  in  1  single-cycle pulse; the accepted write has finished.
- sccb_err  in  1  sampled only with sccb_done; high means NACK or failure.
- busy  out  1  sequence in progress.
- done  out  1  sticky; sequence finished (end marker or address exhaustion).
- err  out  1  sticky; at least one entry failed after all retries, or the end marker was missing.

## Operation
- Reset values: rom_addr=0, cmd_valid=0, cmd_reg=0, cmd_data=0, busy=0, done=0, err=0, state IDLE, retry count 0, delay counter 0.
- IDLE: on start, go to FETCH. Set rom_addr=0, busy=1, clear done and err.
- FETCH: hold rom_addr for one cycle so the ROM can register it, then go to DECODE.
- DECODE: sample rom_dout and branch:
  - 0xFFFF: go to FINISH.
  - 0xFFF0: load the delay counter with DELAY_CYCLES-1 and go to DELAY.
  - Any other value: latch cmd_reg=rom_dout[15:8] and cmd_data=rom_dout[7:0], set retry count 0, go to SEND.
- SEND: assert cmd_valid. cmd_reg and cmd_data stay stable while cmd_valid is high. A transfer occurs when cmd_valid and cmd_ready are both high; then deassert cmd_valid and go to WAIT.
- WAIT: wait for sccb_done.
  - sccb_err=0: go to NEXT.
  - sccb_err=1 and retry count < MAX_RETRY: increment the retry count, return to SEND with the same reg/data.
  - sccb_err=1 and retry count = MAX_RETRY: set err, go to NEXT.
- DELAY: decrement the counter each cycle. When it reaches 0, go to NEXT.
- NEXT:
  - If rom_addr = 255: set err (no end marker) and go to FINISH.
  - Otherwise: rom_addr+1, go to FETCH.
- FINISH: busy=0, done=1, go to IDLE. done stays high until the next start or reset.
- start is ignored while busy=1.
- sccb_done arriving in any state other than WAIT is ignored.
- The delay counter width is clog2(DELAY_CYCLES+1).
- rom_addr is 8-bit and never wraps. Address 255 is the last entry processed.

## Timing
- start sampled high at edge 0: busy=1 and rom_addr=0 in cycle 1 (FETCH); DECODE in cycle 2; cmd_valid=1 in cycle 3 at the earliest.
- Overhead per write entry: NEXT, FETCH and DECODE take 3 cycles, plus the SEND wait for cmd_ready and the WAIT for sccb_done.
- A delay entry occupies DECODE, then exactly DELAY_CYCLES cycles of DELAY, then NEXT.
- The end marker at address k: done=1 and busy=0 are visible 2 cycles after the DECODE cycle that read 0xFFFF.
- cmd_valid is never deasserted before a transfer. It drops the cycle after the transfer.
- Asynchronous rst at any point (including mid-SEND or mid-DELAY) immediately returns all outputs to their reset values. No partial command is held.

## Test plan
- ROM model {0x1280, 0xFFF0, 0x1204, 0xFFFF}, DELAY_CYCLES=20, cmd_ready=1, sccb_done 5 cycles after each transfer -> writes (0x12,0x80) then (0x12,0x04) in order. Exactly 20 DELAY cycles fall between the sccb_done of the first write and the DECODE of address 2. done=1, err=0.
- Same ROM, cmd_ready held low for 7 cycles -> cmd_valid stays high and cmd_reg/cmd_data stay stable throughout. Exactly one transfer per entry.
- sccb_err=1 on the first 2 attempts of entry 0, then OK -> 3 transfers of (0x12,0x80), err=0. With 3 errors (MAX_RETRY=2) -> err=1, and the sequence continues to entry 2 and reaches done=1.
- Second start pulse while busy -> ignored, and the sequence is unchanged. start after done -> done clears and writes restart from address 0.
- rst asserted during DELAY -> busy=0, cmd_valid=0, rom_addr=0 immediately. A new start replays from address 0.
- ROM with 256 normal entries and no 0xFFFF -> 256 writes, then done=1 and err=1. rom_addr never exceeds 255.
